// File: rtl/leitor_banco_reg.sv
// leitor_banco_reg
// Walks one read port of the 32x64 register file from REG_INICIAL to
// REG_FINAL and streams each captured value out as an (index, data) pair
// on a valid/ready interface. It never writes the register file.
//
// Ports
//   clk              in   system clock, rising edge
//   reset            in   asynchronous, active-high
//   iniciar          in   start request, honoured only while idle
//   endereco_leitura out  [4:0]  address to the register file read port
//   valor_lido       in   [63:0] combinational read data for that address
//   dado_saida       out  [63:0] captured register value
//   indice_saida     out  [4:0]  register index of dado_saida
//   saida_valida     out  dado_saida/indice_saida valid
//   saida_pronta     in   downstream accepts the current word
//   ocupado          out  dump in progress
//   fim              out  one-cycle pulse after the last word is accepted
//
// state   | meaning
// OCIOSO  | idle, waiting for iniciar
// LEITURA | address on the read port, value captured at the edge
// ENVIO   | word presented, waiting for saida_pronta
// FIM     | last word accepted, fim pulse, back to idle

module leitor_banco_reg #(
    parameter logic [4:0] REG_INICIAL = 5'd0,
    parameter logic [4:0] REG_FINAL   = 5'd31
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        iniciar,
    output logic [4:0]  endereco_leitura,
    input  logic [63:0] valor_lido,
    output logic [63:0] dado_saida,
    output logic [4:0]  indice_saida,
    output logic        saida_valida,
    input  logic        saida_pronta,
    output logic        ocupado,
    output logic        fim
);

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        LEITURA = 2'd1,
        ENVIO   = 2'd2,
        FIM     = 2'd3
    } estado_t;

    estado_t     estado_q;
    logic [4:0]  indice_q;
    logic [63:0] dado_q;
    logic [4:0]  indice_saida_q;
    logic        valida_q;
    logic        ocupado_q;
    logic        fim_q;

    // All outputs are loaded together with the state transition, so every
    // output is a flop and saida_pronta never reaches an output combinationally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado_q       <= OCIOSO;
            indice_q       <= 5'd0;
            dado_q         <= 64'd0;
            indice_saida_q <= 5'd0;
            valida_q       <= 1'b0;
            ocupado_q      <= 1'b0;
            fim_q          <= 1'b0;
        end else begin
            fim_q <= 1'b0;
            case (estado_q)
                OCIOSO: begin
                    if (iniciar) begin
                        indice_q  <= REG_INICIAL;
                        ocupado_q <= 1'b1;
                        estado_q  <= LEITURA;
                    end
                end
                LEITURA: begin
                    dado_q         <= valor_lido;
                    indice_saida_q <= indice_q;
                    valida_q       <= 1'b1;
                    estado_q       <= ENVIO;
                end
                ENVIO: begin
                    if (saida_pronta) begin
                        valida_q <= 1'b0;
                        if (indice_q == REG_FINAL) begin
                            // index stays at REG_FINAL; never wraps
                            fim_q    <= 1'b1;
                            estado_q <= FIM;
                        end else begin
                            indice_q <= indice_q + 5'd1;
                            estado_q <= LEITURA;
                        end
                    end
                end
                FIM: begin
                    ocupado_q <= 1'b0;
                    estado_q  <= OCIOSO;
                end
                default: begin
                    valida_q  <= 1'b0;
                    ocupado_q <= 1'b0;
                    estado_q  <= OCIOSO;
                end
            endcase
        end
    end

    assign endereco_leitura = indice_q;
    assign dado_saida       = dado_q;
    assign indice_saida     = indice_saida_q;
    assign saida_valida     = valida_q;
    assign ocupado          = ocupado_q;
    assign fim              = fim_q;

endmodule

// File: tb/tb_leitor_banco_reg.sv
// Directed bench for leitor_banco_reg: three instances (full range, 5..7,
// 9..9) share one behavioural register file with x0 hardwired to zero.
module tb_leitor_banco_reg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        pronta;
    logic        ini     [3];
    logic [4:0]  ender   [3];
    logic [63:0] vl      [3];
    logic [63:0] dado    [3];
    logic [4:0]  idx_o   [3];
    logic        valida  [3];
    logic        ocup    [3];
    logic        fim_o   [3];

    logic [63:0] rf     [32];
    logic [63:0] exp_rf [32];

    int n_cmp = 0;
    int n_err = 0;

    for (genvar g = 0; g < 3; g++) begin : g_rd
        assign vl[g] = (ender[g] == 5'd0) ? 64'd0 : rf[ender[g]];
    end

    leitor_banco_reg u_dut0 (
        .clk(clk), .reset(reset), .iniciar(ini[0]), .endereco_leitura(ender[0]),
        .valor_lido(vl[0]), .dado_saida(dado[0]), .indice_saida(idx_o[0]),
        .saida_valida(valida[0]), .saida_pronta(pronta), .ocupado(ocup[0]), .fim(fim_o[0])
    );

    leitor_banco_reg #(.REG_INICIAL(5'd5), .REG_FINAL(5'd7)) u_dut1 (
        .clk(clk), .reset(reset), .iniciar(ini[1]), .endereco_leitura(ender[1]),
        .valor_lido(vl[1]), .dado_saida(dado[1]), .indice_saida(idx_o[1]),
        .saida_valida(valida[1]), .saida_pronta(pronta), .ocupado(ocup[1]), .fim(fim_o[1])
    );

    leitor_banco_reg #(.REG_INICIAL(5'd9), .REG_FINAL(5'd9)) u_dut2 (
        .clk(clk), .reset(reset), .iniciar(ini[2]), .endereco_leitura(ender[2]),
        .valor_lido(vl[2]), .dado_saida(dado[2]), .indice_saida(idx_o[2]),
        .saida_valida(valida[2]), .saida_pronta(pronta), .ocupado(ocup[2]), .fim(fim_o[2])
    );

    task automatic verifica(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic init_rf();
        for (int i = 0; i < 32; i++) begin
            rf[i]     = 64'(i);
            exp_rf[i] = 64'(i);
        end
    endtask

    // One dump on instance sel. e counts observations taken 1 ns after each
    // edge; observation e follows edge E(e-1), E0 being the iniciar edge.
    task automatic run_dump(input string nome, input int sel, input int first, input int n,
                            input int stall_k, input int stall_n, input bit spam, input bit wr);
        int  e;
        int  cur;
        int  held;
        int  fim_cnt;
        int  fim_e;
        int  fall_e;
        int  exp_rise;
        bit  pv;
        e = 0; cur = -1; held = 0; fim_cnt = 0; fim_e = -1; fall_e = -1; pv = 1'b0;
        pronta   = 1'b1;
        ini[sel] = 1'b1;
        while (fall_e < 0 && e < 400) begin
            @(posedge clk);
            #1;
            e++;
            ini[sel] = spam;
            if (valida[sel] && !pv) begin
                cur++;
                exp_rise = 2 * cur + 2 + ((cur > stall_k) ? stall_n : 0);
                verifica({nome, "_idx"}, 64'(idx_o[sel]), 64'(first + cur));
                verifica({nome, "_dado"}, dado[sel], exp_rf[(first + cur) % 32]);
                verifica({nome, "_instante"}, 64'(e), 64'(exp_rise));
                if (wr && cur == 2) begin
                    rf[10] = 64'hDEAD_BEEF;
                    rf[1]  = 64'h55;
                end
            end else if (valida[sel]) begin
                verifica({nome, "_retido_idx"}, 64'(idx_o[sel]), 64'(first + cur));
                verifica({nome, "_retido_dado"}, dado[sel], exp_rf[(first + cur) % 32]);
            end
            pv     = valida[sel];
            pronta = !(valida[sel] && cur == stall_k && held < stall_n);
            if (!pronta) held++;
            if (fim_o[sel]) begin
                fim_cnt++;
                fim_e = e;
            end
            if (!ocup[sel]) begin
                fall_e   = e;
                ini[sel] = 1'b0;
            end
        end
        if (fall_e < 0) verifica({nome, "_timeout"}, 64'd0, 64'd1);
        ini[sel] = 1'b0;
        pronta   = 1'b1;
        verifica({nome, "_palavras"}, 64'(cur + 1), 64'(n));
        verifica({nome, "_n_fim"}, 64'(fim_cnt), 64'd1);
        verifica({nome, "_instante_fim"}, 64'(fim_e), 64'(2 * n + 1 + stall_n));
        verifica({nome, "_instante_livre"}, 64'(fall_e), 64'(2 * n + 2 + stall_n));
    endtask

    initial begin
        bit achou;
        init_rf();
        reset  = 1'b1;
        pronta = 1'b1;
        for (int i = 0; i < 3; i++) ini[i] = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        verifica("rst_ender", 64'(ender[0]), 64'd0);
        verifica("rst_dado", dado[0], 64'd0);
        verifica("rst_idx", 64'(idx_o[0]), 64'd0);
        verifica("rst_valida", 64'(valida[0]), 64'd0);
        verifica("rst_ocupado", 64'(ocup[0]), 64'd0);
        verifica("rst_fim", 64'(fim_o[0]), 64'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        run_dump("completo", 0, 0, 32, -1, 0, 1'b0, 1'b0);
        run_dump("contrapressao", 0, 0, 32, 3, 5, 1'b0, 1'b0);
        run_dump("faixa_5_7", 1, 5, 3, -1, 0, 1'b0, 1'b0);
        run_dump("faixa_9_9", 2, 9, 1, -1, 0, 1'b0, 1'b0);

        exp_rf[10] = 64'hDEAD_BEEF;
        run_dump("escrita", 0, 0, 32, -1, 0, 1'b0, 1'b1);
        init_rf();

        run_dump("inicio_repetido", 0, 0, 32, -1, 0, 1'b1, 1'b0);

        // reset between edges while word 12 is presented
        achou = 1'b0;
        ini[0] = 1'b1;
        for (int i = 0; i < 100 && !achou; i++) begin
            @(posedge clk);
            #1;
            ini[0] = 1'b0;
            if (valida[0] && idx_o[0] == 5'd12) achou = 1'b1;
        end
        verifica("rst_meio_achou12", 64'(achou), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        verifica("rst_meio_valida", 64'(valida[0]), 64'd0);
        verifica("rst_meio_ocupado", 64'(ocup[0]), 64'd0);
        verifica("rst_meio_fim", 64'(fim_o[0]), 64'd0);
        verifica("rst_meio_ender", 64'(ender[0]), 64'd0);
        verifica("rst_meio_dado", dado[0], 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        verifica("pos_rst_ocioso", 64'(ocup[0]), 64'd0);
        run_dump("reinicio", 0, 0, 32, -1, 0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
